// File: rtl/usb_hub_pkg.sv
// Shared USB hub types: bus line states, receiver FSM states and default
// SYNC / bit-stuffing limits.
package usb_hub_pkg;

  // Encoded as {D+, D-}
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ABORT
  } rx_state_t;

  localparam int DEF_SYNC_MIN_ZEROS = 3;
  localparam int DEF_STUFF_LIMIT    = 6;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

  function automatic logic is_jk(input line_state_t ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder with bit-stuffing tracker: classifies each J/K tick as a data
// bit, a stuffed zero to drop, or a stuffing violation.
module usb_nrzi_unstuff
  import usb_hub_pkg::*;
#(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic        hi_clock,
  input  logic        reset,
  input  logic        bit_tick,
  input  line_state_t line,
  input  logic        track,
  input  logic        preload,
  output logic        bit_val,
  output logic        stuff_bit,
  output logic        stuff_err
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);

  line_state_t   prev_jk;
  logic [OW-1:0] ones_cnt;
  logic          jk;
  logic          at_limit;

  always_comb begin
    jk        = is_jk(line);
    at_limit  = (ones_cnt == OW'(STUFF_LIMIT));
    bit_val   = jk && (line == prev_jk);
    stuff_bit = track && at_limit && jk && !bit_val;
    stuff_err = track && at_limit && bit_val;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge hi_clock or posedge reset) begin
    if (reset) begin
      prev_jk  <= LS_J;
      ones_cnt <= '0;
    end else if (bit_tick) begin
      if (jk)
        prev_jk <= line;
      // The SYNC-terminating one is the first of a potential stuffing run
      if (preload)
        ones_cnt <= OW'(1);
      else if (track && jk) begin
        if (at_limit || !bit_val)
          ones_cnt <= '0;
        else
          ones_cnt <= ones_cnt + OW'(1);
      end
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB low/full-speed receive decoder: SYNC detection, byte assembly from the
// unstuffed NRZI stream, EOP checking and abort recovery.
module usb_rx_decoder
  import usb_hub_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = DEF_SYNC_MIN_ZEROS,
  parameter int STUFF_LIMIT    = DEF_STUFF_LIMIT
) (
  input  logic       hi_clock,
  input  logic       reset,
  input  logic       bit_tick,
  input  logic       host_rx_plus,
  input  logic       host_rx_minus,
  output logic       rx_active,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_error
);

  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);

  rx_state_t   state, state_n;
  line_state_t line;
  logic        bit_val, stuff_bit, stuff_err;
  logic [ZW-1:0] zero_cnt;
  logic [1:0]  se0_cnt;
  logic        j_seen;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic        sync_done, data_bit, byte_done, err;
  logic        active_n, valid_n;

  assign line = decode_line(host_rx_plus, host_rx_minus);

  usb_nrzi_unstuff #(.STUFF_LIMIT(STUFF_LIMIT)) u_nrzi (
    .hi_clock  (hi_clock),
    .reset     (reset),
    .bit_tick  (bit_tick),
    .line      (line),
    .track     (state == ST_DATA),
    .preload   (sync_done),
    .bit_val   (bit_val),
    .stuff_bit (stuff_bit),
    .stuff_err (stuff_err)
  );

  always_ff @(posedge hi_clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    err       = 1'b0;
    sync_done = 1'b0;
    data_bit  = 1'b0;
    if (bit_tick) begin
      if (line == LS_SE1 && state != ST_IDLE) begin
        state_n = ST_ABORT;
        err     = 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (line == LS_K) state_n = ST_SYNC;
          ST_SYNC: begin
            if (line == LS_SE0)
              state_n = ST_IDLE;
            else if (bit_val) begin
              if (zero_cnt >= ZW'(SYNC_MIN_ZEROS)) begin
                state_n   = ST_DATA;
                sync_done = 1'b1;
              end else
                state_n = ST_IDLE;
            end
          end
          ST_DATA: begin
            if (line == LS_SE0)
              state_n = ST_EOP;
            else if (stuff_err) begin
              state_n = ST_ABORT;
              err     = 1'b1;
            end else if (!stuff_bit)
              data_bit = 1'b1;
          end
          ST_EOP: begin
            // A third SE0 or a K inside EOP is a framing error
            if ((line == LS_SE0 && se0_cnt == 2'd2) || line == LS_K) begin
              state_n = ST_ABORT;
              err     = 1'b1;
            end else if (line == LS_J) begin
              state_n = ST_IDLE;
              err     = (bit_cnt != 3'd0);
            end
          end
          ST_ABORT: if (line == LS_J && j_seen) state_n = ST_IDLE;
          default:  state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    byte_done = data_bit && (bit_cnt == 3'd7);
    active_n  = (state_n == ST_DATA) || (state_n == ST_EOP);
    valid_n   = byte_done && !err;
  end

  always_ff @(posedge hi_clock or posedge reset) begin
    if (reset) begin
      zero_cnt  <= '0;
      se0_cnt   <= '0;
      j_seen    <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_active <= 1'b0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      rx_active <= active_n;
      rx_valid  <= valid_n;
      rx_error  <= err;
      if (valid_n)
        rx_data <= {bit_val, shift};
      if (bit_tick) begin
        if (state == ST_IDLE)
          zero_cnt <= '0;
        else if (state == ST_SYNC && is_jk(line) && !bit_val &&
                 zero_cnt < ZW'(SYNC_MIN_ZEROS))
          zero_cnt <= zero_cnt + ZW'(1);
        if (state_n == ST_EOP)
          se0_cnt <= (state == ST_EOP) ? se0_cnt + 2'd1 : 2'd1;
        else
          se0_cnt <= 2'd0;
        j_seen <= (state == ST_ABORT) && (line == LS_J);
        if (data_bit) begin
          bit_cnt <= bit_cnt + 3'd1;
          shift   <= {bit_val, shift[6:1]};
        end else if (state != ST_DATA && state != ST_EOP)
          bit_cnt <= 3'd0;
      end
    end
  end

endmodule
